// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - indexed table of saturating branch counters with branch/mispredict statistics
// Optional gshare indexing (global history XOR PC) enabled by defining BP_GSHARE_EN.
module branch_predictor_bht #(
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 32,
  parameter int HIST_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [29:0]       lk_pc,
  input  logic              lk_is_branch,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_mispred,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispreds
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST  = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [CTR_W-1:0] ctr_q [DEPTH];
  logic             accept;
  logic [CTR_W-1:0] ctr_old;
  logic [CTR_W-1:0] ctr_new;
  logic             unused_pc_bits;

  assign accept         = upd_valid & ~stall;
  assign unused_pc_bits = ^lk_pc[29:IDX_W];

`ifdef BP_GSHARE_EN
  // History is non-speculative: it advances only on resolved, accepted updates.
  logic [HIST_W-1:0] ghr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (accept) begin
      ghr_q <= HIST_W'({ghr_q, upd_taken});
    end
  end

  assign pred_idx = lk_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);
`else
  assign pred_idx = lk_pc[IDX_W-1:0];
`endif

  // Lookup reads the registered table, so a same-cycle update to this index is not bypassed.
  assign pred_taken = lk_is_branch & ctr_q[pred_idx][CTR_W-1];

  always_comb begin
    ctr_old = ctr_q[upd_idx];
    ctr_new = ctr_old;
    if (upd_taken) begin
      if (ctr_old != CTR_MAX) ctr_new = ctr_old + CTR_W'(1);
    end else begin
      if (ctr_old != '0) ctr_new = ctr_old - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
    end else if (accept) begin
      ctr_q[upd_idx] <= ctr_new;
    end
  end

  // Clear takes priority over a coincident update and ignores stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispreds <= '0;
    end else if (stat_clr) begin
      stat_branches <= '0;
      stat_mispreds <= '0;
    end else if (accept) begin
      if (stat_branches != STAT_MAX) stat_branches <= stat_branches + STAT_W'(1);
      if (upd_mispred && (stat_mispreds != STAT_MAX)) stat_mispreds <= stat_mispreds + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - vector table and scoreboard bench for branch_predictor_bht
module tb_branch_predictor_bht;
  localparam int IDX_W  = 6;
  localparam int CTR_W  = 2;
  localparam int STAT_W = 4;
  localparam int HIST_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic [29:0]       lk_pc;
  logic              lk_is_branch;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_mispred;
  logic              stat_clr;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispreds;

  always #5 clk = ~clk;

  branch_predictor_bht #(.IDX_W(IDX_W), .CTR_W(CTR_W), .STAT_W(STAT_W), .HIST_W(HIST_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .lk_pc(lk_pc), .lk_is_branch(lk_is_branch),
    .pred_taken(pred_taken), .pred_idx(pred_idx), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .stat_clr(stat_clr),
    .stat_branches(stat_branches), .stat_mispreds(stat_mispreds)
  );

  typedef struct {
    logic        stall;
    logic        valid;
    logic [5:0]  idx;
    logic        taken;
    logic        mis;
    logic        clr;
    logic [29:0] pc;
    logic        br;
    logic        exp_pt;
    logic [5:0]  exp_idx;
    int          exp_br;
    int          exp_mis;
  } vec_t;

  typedef struct {
    logic       pt;
    logic [5:0] idx;
    int         br;
    int         mis;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic cmp(string nm, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic add(int st, int va, int ix, int tk, int ms, int cl, int pc, int br,
                     int pt, int ei, int eb, int em);
    vec_t v;
    v.stall = 1'(st); v.valid = 1'(va); v.idx = 6'(ix); v.taken = 1'(tk);
    v.mis = 1'(ms); v.clr = 1'(cl); v.pc = 30'(pc); v.br = 1'(br);
    v.exp_pt = 1'(pt); v.exp_idx = 6'(ei); v.exp_br = eb; v.exp_mis = em;
    vecs.push_back(v);
  endtask

  task automatic drive(vec_t v);
    exp_t e;
    stall = v.stall; upd_valid = v.valid; upd_idx = v.idx; upd_taken = v.taken;
    upd_mispred = v.mis; stat_clr = v.clr; lk_pc = v.pc; lk_is_branch = v.br;
    e.pt = v.exp_pt; e.idx = v.exp_idx; e.br = v.exp_br; e.mis = v.exp_mis;
    exp_q.push_back(e);
  endtask

  task automatic check_out(string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp({nm, " scoreboard_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    cmp({nm, " pred_taken"}, int'(pred_taken), int'(e.pt));
    cmp({nm, " pred_idx"}, int'(pred_idx), int'(e.idx));
    cmp({nm, " stat_branches"}, int'(stat_branches), e.br);
    cmp({nm, " stat_mispreds"}, int'(stat_mispreds), e.mis);
  endtask

  task automatic expect_now(string nm, int pt, int ix, int br, int mis);
    exp_t e;
    e.pt = 1'(pt); e.idx = 6'(ix); e.br = br; e.mis = mis;
    exp_q.push_back(e);
    check_out(nm);
  endtask

  task automatic idle();
    stall = 0; upd_valid = 0; upd_idx = '0; upd_taken = 0; upd_mispred = 0; stat_clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; idle(); lk_pc = 30'h5; lk_is_branch = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

`ifdef BP_GSHARE_EN
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1
      upd_valid = 1; upd_idx = '0; upd_taken = (i < 2);
    end
    @(posedge clk); #1
    idle(); lk_pc = 30'h9; lk_is_branch = 1;
    #1 expect_now("gshare_idx", 0, 8'h0F, 3, 0);
    rst_n = 0;
    #1 expect_now("gshare_rst", 0, 8'h09, 0, 0);
    @(posedge clk); #1 rst_n = 1;
`else
    //  st va ix tk ms cl  pc          br  pt ei  br mis
    add(0, 0, 0, 0, 0, 0, 5,          1,  0, 5,  0, 0);
    add(0, 0, 0, 0, 0, 0, 5,          0,  0, 5,  0, 0);
    add(0, 1, 5, 1, 0, 0, 5,          1,  0, 5,  0, 0);
    add(0, 1, 5, 1, 0, 0, 5,          1,  1, 5,  1, 0);
    add(0, 1, 5, 1, 1, 0, 5,          1,  1, 5,  2, 0);
    add(0, 0, 0, 0, 0, 0, 5,          0,  0, 5,  3, 1);
    add(0, 1, 5, 0, 1, 0, 6,          1,  0, 6,  3, 1);
    add(0, 1, 5, 0, 0, 0, 5,          1,  1, 5,  4, 2);
    add(0, 1, 5, 0, 0, 0, 5,          1,  0, 5,  5, 2);
    add(0, 1, 5, 0, 1, 0, 6,          1,  0, 6,  6, 2);
    add(0, 1, 5, 1, 0, 0, 5,          1,  0, 5,  7, 3);
    add(0, 1, 5, 1, 0, 0, 5,          1,  0, 5,  8, 3);
    add(0, 0, 0, 0, 0, 0, 5,          1,  1, 5,  9, 3);
    add(1, 1, 7, 1, 1, 0, 7,          1,  0, 7,  9, 3);
    add(1, 1, 7, 1, 1, 0, 7,          1,  0, 7,  9, 3);
    add(1, 1, 7, 1, 1, 0, 7,          1,  0, 7,  9, 3);
    add(0, 1, 7, 1, 0, 0, 7,          1,  0, 7,  9, 3);
    add(0, 0, 0, 0, 0, 0, 7,          1,  1, 7, 10, 3);
    add(0, 1, 8, 1, 1, 1, 8,          1,  0, 8, 10, 3);
    add(0, 0, 0, 0, 0, 0, 8,          1,  1, 8,  0, 0);
    add(0, 1, 9, 0, 1, 0, 9,          1,  0, 9,  0, 0);
    add(1, 0, 0, 0, 0, 1, 9,          1,  0, 9,  1, 1);
    add(0, 0, 0, 0, 0, 0, 'h2AAAAA85, 1,  1, 5,  0, 0);

    foreach (vecs[i]) begin
      @(posedge clk); #1
      drive(vecs[i]);
      #3 check_out($sformatf("vec%0d", i));
    end

    // Reset mid-operation discards the in-flight update and restores reset state at once.
    @(posedge clk); #1
    idle(); upd_valid = 1; upd_idx = 6'd5; upd_taken = 1; lk_pc = 30'h5; lk_is_branch = 1;
    rst_n = 0;
    #1 expect_now("mid_reset", 0, 5, 0, 0);
    @(posedge clk); #1
    rst_n = 1; idle();
    #1 expect_now("post_reset", 0, 5, 0, 0);

    // Statistics saturate at all-ones instead of wrapping.
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1
      upd_valid = 1; upd_idx = 6'd10; upd_taken = 1; upd_mispred = 1;
    end
    @(posedge clk); #1
    idle(); lk_pc = 30'hA;
    #1 expect_now("stat_sat", 1, 10, 15, 15);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised dynamic branch predictor that replaces the single global 2-bit predictor in the MIPS pipeline.
- Holds a table of 2^IDX_W saturating counters, each CTR_W bits wide, indexed by instruction word-address bits. The IF stage queries it combinationally.
- The ID stage resolves the branch and writes the outcome back one or more cycles later.
- Also keeps branch and misprediction statistics counters for performance evaluation.

Parameters:
- IDX_W, 6, index width; table depth = 2^IDX_W entries (legal 2..10).
- CTR_W, 2, saturating counter width per entry (legal 1..4).
- STAT_W, 32, width of the statistics counters.
- HIST_W, 6, global history length, used only with BP_GSHARE_EN (legal 1..IDX_W).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- stall, in, 1, pipeline freeze (ICACHE_stall | DCACHE_stall); blocks all state updates.
- lk_pc, in, 30, word address (PC[31:2]) of the instruction currently in IF.
- lk_is_branch, in, 1, IF instruction opcode is BEQ/BNE.
- pred_taken, out, 1, prediction for lk_pc; forced 0 when lk_is_branch=0.
- pred_idx, out, IDX_W, table index used for this lookup; the pipeline carries it into IF/ID.
- upd_valid, in, 1, resolved branch in ID this cycle.
- upd_idx, in, IDX_W, pred_idx carried with the resolved branch.
- upd_taken, in, 1, actual outcome.
- upd_mispred, in, 1, prediction was wrong (drives statistics only).
- stat_clr, in, 1, synchronous clear of the statistics counters.
- stat_branches, out, STAT_W, count of accepted updates.
- stat_mispreds, out, STAT_W, count of accepted updates with upd_mispred=1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Every table entry is set to weakly-not-taken, value 2^(CTR_W-1)-1. For CTR_W=1 that value is 0.
  - Global history is 0; stat_branches and stat_mispreds are 0.
  - pred_taken follows the reset table, so it is 0.
  - pred_idx is combinational, so it follows lk_pc even during reset.
- Lookup (combinational, zero latency):
  - pred_idx = lk_pc[IDX_W-1:0].
  - pred_taken = lk_is_branch & entry[pred_idx][CTR_W-1].
- Update acceptance:
  - An update is accepted on a rising clk edge where upd_valid=1 and stall=0.
  - While stall=1, upd_valid is ignored and the pipeline re-presents the update.
- Counter arithmetic per accepted update:
  - upd_taken=1: increment, saturating at 2^CTR_W-1.
  - upd_taken=0: decrement, saturating at 0.
  - There is no wrap-around in either direction.
- Read-during-write:
  - A lookup in the same cycle as an accepted update to the same index sees the old value.
  - The new value is visible from the next cycle. There is no bypass.
- Statistics:
  - stat_branches increments by 1 per accepted update.
  - stat_mispreds increments by 1 per accepted update with upd_mispred=1.
  - Both saturate at all-ones.
  - stat_clr=1 forces both to 0 on the next edge, regardless of stall. If stat_clr and an accepted update occur together, clear wins and the result is 0.
- upd_mispred does not affect table contents.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight updates are discarded.
- An update with an out-of-range index cannot occur, since the index is IDX_W bits wide.

Optional Feature:
- Macro: BP_GSHARE_EN.
- When defined:
  - A HIST_W-bit global history register GHR shifts left on every accepted update, shifting in upd_taken. It is held while stall=1 and reset to 0.
  - pred_idx = lk_pc[IDX_W-1:0] XOR {zero-extended GHR} (GHR aligned to bit 0).
  - The update uses upd_idx unchanged, so the entry written is the one that was read at lookup.
  - The history is non-speculative: it is not updated at lookup.
- When undefined:
  - No GHR is instantiated.
  - The index is the pure PC bits as above.

Test Plan:
1. Reset, lk_pc=30'h5, lk_is_branch=1 -> pred_taken=0, pred_idx=5 (IDX_W=6); stat_branches=0, stat_mispreds=0.
2. Two accepted updates to idx 5 with upd_taken=1 -> counter 01->10->11; pred_taken=1 from the cycle after the first update. A third taken update keeps the counter at 11.
3. From counter 11 at idx 5, four not-taken updates -> 10,01,00,00; pred_taken goes 0 after the second. Meanwhile, lookup of idx 6 stays at 01 throughout.
4. upd_valid=1 with stall=1 for 3 cycles, then stall=0 for 1 cycle -> exactly one counter step and stat_branches +1. Same-cycle lookup of the same index returns the pre-update value.
5. Ten updates, 3 with upd_mispred=1 -> stat_branches=10, stat_mispreds=3. stat_clr concurrent with an 11th update -> both counters 0.
6. BP_GSHARE_EN with IDX_W=6, HIST_W=6: after taken,taken,not-taken updates, GHR=3'b110 -> lookup at lk_pc=30'h9 gives pred_idx=6'h0F. rst_n pulse -> GHR=0 and pred_idx=6'h09.
